myproject_mul_pipe_rs: RTL and testbench
========================================

Name: myproject_mul_pipe_rs

Overview:
- Parametrised, pipelined, multi-lane signed multiplier with valid/ready flow control, post-product arithmetic shift, optional rounding and optional saturation to the output width.
- Successor to the single-cycle combinational multiply primitives used inside dense/activation datapaths.
- Used where products must be requantised to a narrower fixed-point format and where the downstream consumer can stall.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, pipeline register stages, legal range 1..8; 0 is an elaboration error.
- LANES, 1, independent multiply lanes sharing one handshake, range 1..16.
- din0_WIDTH, 14, per-lane signed width of operand A.
- din1_WIDTH, 12, per-lane signed width of operand B.
- dout_WIDTH, 16, per-lane signed result width.
- SHIFT, 8, arithmetic right shift applied to the full product, range 0..(din0_WIDTH+din1_WIDTH-1).
- ROUND, 1, 1 = round-half-up (add 2^(SHIFT-1) before the shift; ignored when SHIFT=0); 0 = truncate toward minus infinity.
- SAT, 1, 1 = clamp to the signed dout range; 0 = wrap (keep the low dout_WIDTH bits).
- CNT_WIDTH, 16, width of the overflow counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- din0  in  LANES*din0_WIDTH  packed A operands; lane 0 in the LSBs.
- din1  in  LANES*din1_WIDTH  packed B operands.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  LANES*dout_WIDTH  packed results.
- ovf  out  LANES  per-lane overflow flag, aligned with dout.
- ovf_cnt  out  CNT_WIDTH  count of output beats with any ovf bit set; saturates at all-ones.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0, dout = 0, ovf = 0, ovf_cnt = 0, out_valid = 0. A beat that is mid-pipeline is discarded. in_ready is combinational and is 1 during reset deassertion if ce = 1.
- Advance: adv = ce & (~out_valid | out_ready). in_ready = adv. A beat is accepted when in_valid & adv.
- The whole pipeline shifts on adv, including bubbles. There is no bubble compression.
- Latency is exactly NUM_STAGE cycles from acceptance to out_valid when there are no stalls. Throughput is 1 beat per cycle.
- Stall (out_valid & ~out_ready): every stage holds. dout, ovf and out_valid stay stable until the transfer completes.
- ce low: everything holds, in_ready = 0, and a pending output transfer does not complete.
- Arithmetic per lane:
  - P = signed(A) * signed(B), din0_WIDTH+din1_WIDTH bits, exact.
  - If ROUND and SHIFT > 0: Q = (P + 2^(SHIFT-1)) >>> SHIFT, computed with 1 guard bit so there is no intermediate overflow.
  - Otherwise Q = P >>> SHIFT.
  - If SAT: dout = clamp(Q, -2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1), and ovf = 1 when clamping occurred.
  - If not SAT: dout = Q[dout_WIDTH-1:0], and ovf = 1 when Q does not fit the signed dout range.
  - If Q is never wider than dout_WIDTH, ovf ties low.
- Placement: the multiply is in stage 1. Round/shift/saturate is in the final stage (in stage 1 as well when NUM_STAGE = 1). Intermediate stages carry P only.
- ovf_cnt increments by 1 on each output transfer (out_valid & out_ready & ce) with |ovf. It holds at 2^CNT_WIDTH-1.
- ovf_clr has priority over a simultaneous increment; the result is 0.
- Simultaneous accept and output transfer in the same cycle is legal and loses no data.

Decomposition:
- Shared package myproject_mul_pkg: rounding/saturation mode constants, and a function sat_shift(P, SHIFT, ROUND, SAT) returning {ovf, dout} for one lane.
- One sub-module, myproject_mul_lane_rs: one lane's multiply plus a P-carry register chain, instantiated LANES times via generate.
- Handshake control and ovf_cnt live in the top module.

Test Plan:
- Defaults, A=100, B=200 -> Q = 20000 >>> 8 = 78; dout = 78, ovf = 0, out_valid exactly 2 cycles after acceptance.
- A=-3, B=5 (P=-15): ROUND=1 -> dout = 0; ROUND=0 -> dout = -1.
- A=8191, B=2047 (P=16766977, Q=65496): SAT=1 -> dout = 32767, ovf = 1, ovf_cnt = 1. SAT=0 -> dout = -40, ovf = 1. A=-8192, B=2047 with SAT=1 -> dout = -32768, ovf = 1.
- Stream 10 beats back-to-back while out_ready is low for cycles 3..6 -> in_ready drops, outputs hold stable, all 10 results delivered in order with none lost or duplicated.
- LANES=4, NUM_STAGE=3, lanes (1,1), (-2,3), (127,-1), (0,5) with SHIFT=0 -> dout lanes 1, -6, -127, 0 after 3 cycles.
- Assert reset mid-stream with 2 beats in flight -> out_valid = 0, ovf_cnt = 0 immediately. After release, the next beat alone emerges. ovf_clr asserted together with an overflow transfer -> ovf_cnt = 0.

Source files
------------

// File: rtl/myproject_mul_pkg.sv
// Shared constants and the per-lane requantise function for the pipelined multiplier.
package myproject_mul_pkg;

    // Widest product the requantise function handles (din0_WIDTH + din1_WIDTH must not exceed this).
    localparam int P_MAX = 64;

    localparam bit RND_TRUNC   = 1'b0;
    localparam bit RND_HALF_UP = 1'b1;
    localparam bit SAT_WRAP    = 1'b0;
    localparam bit SAT_CLAMP   = 1'b1;

    // ovf sits in the LSB so callers can narrow the result with a size cast to dout_WIDTH+1 bits.
    typedef struct packed {
        logic [P_MAX-1:0] dout;
        logic             ovf;
    } sat_res_t;

    // Round/shift/saturate one signed product. The extra MSB is the guard bit for the rounding add.
    function automatic sat_res_t sat_shift(input logic signed [P_MAX-1:0] p,
                                           input int shift, input bit rnd,
                                           input bit sat, input int dw);
        logic signed [P_MAX:0] q, hi, lo, one;
        sat_res_t r;
        one    = '0;
        one[0] = 1'b1;
        q = {p[P_MAX-1], p};
        if (rnd == RND_HALF_UP && shift > 0)
            q = q + (one <<< (shift - 1));
        q  = q >>> shift;
        hi = (one <<< (dw - 1)) - one;
        lo = -(one <<< (dw - 1));
        r.ovf = (q > hi) || (q < lo);
        if (sat == SAT_CLAMP && q > hi)
            r.dout = hi[P_MAX-1:0];
        else if (sat == SAT_CLAMP && q < lo)
            r.dout = lo[P_MAX-1:0];
        else
            r.dout = q[P_MAX-1:0];
        return r;
    endfunction

endpackage

// File: rtl/myproject_mul_lane_rs.sv
// One multiply lane: product in stage 1, P carried through middle stages, requantised into the last stage.
module myproject_mul_lane_rs
    import myproject_mul_pkg::*;
#(
    parameter int NUM_STAGE = 2,
    parameter int AW        = 14,
    parameter int BW        = 12,
    parameter int OW        = 16,
    parameter int SHIFT     = 8,
    parameter bit ROUND     = 1'b1,
    parameter bit SAT       = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [OW-1:0] dout,
    output logic          ovf
);

    localparam int PW = AW + BW;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_last;
    logic [OW-1:0]        dout_n;
    logic                 ovf_n;

    // Full-precision product; sign-extended operands make PW bits exact.
    assign prod = PW'($signed(a)) * PW'($signed(b));

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign p_last = prod;
        end else begin : g_carry
            logic signed [PW-1:0] p_pipe [1:NUM_STAGE-1];

            // P carry chain: stage 1 captures the product, later stages just shift it along.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 1; s < NUM_STAGE; s++) p_pipe[s] <= '0;
                end else if (adv) begin
                    p_pipe[1] <= prod;
                    for (int s = 2; s < NUM_STAGE; s++) p_pipe[s] <= p_pipe[s-1];
                end
            end

            assign p_last = p_pipe[NUM_STAGE-1];
        end
    endgenerate

    assign {dout_n, ovf_n} = (OW+1)'(sat_shift(P_MAX'(p_last), SHIFT, ROUND, SAT, OW));

    // Final stage register: requantised result and its overflow flag stay together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (adv) begin
            dout <= dout_n;
            ovf  <= ovf_n;
        end
    end

endmodule

// File: rtl/myproject_mul_pipe_rs.sv
// Multi-lane pipelined signed multiplier with valid/ready flow control and an overflow beat counter.
module myproject_mul_pipe_rs
    import myproject_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int LANES      = 1,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter bit ROUND      = 1'b1,
    parameter bit SAT        = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*din0_WIDTH-1:0]   din0,
    input  logic [LANES*din1_WIDTH-1:0]   din1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*dout_WIDTH-1:0]   dout,
    output logic [LANES-1:0]              ovf,
    output logic [CNT_WIDTH-1:0]          ovf_cnt,
    input  logic                          ovf_clr
);

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
            $error("myproject_mul_pipe_rs %0d: NUM_STAGE must be 1..8", ID);
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("myproject_mul_pipe_rs %0d: LANES must be 1..16", ID);
        end
    endgenerate

    logic                 adv;
    logic                 xfer;
    logic [NUM_STAGE:1]   vld_pipe;

    // The whole pipe moves together (bubbles included) whenever the output slot is free or draining.
    assign adv       = ce & (~out_valid | out_ready);
    assign in_ready  = adv;
    assign out_valid = vld_pipe[NUM_STAGE];
    assign xfer      = out_valid & out_ready & ce;

    // Valid shift register tracking which stages hold a real beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int s = 2; s <= NUM_STAGE; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // Count delivered beats with any lane overflowing; clear wins, and the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (ce) begin
            if (ovf_clr)
                ovf_cnt <= '0;
            else if (xfer && (|ovf) && (ovf_cnt != {CNT_WIDTH{1'b1}}))
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            myproject_mul_lane_rs #(
                .NUM_STAGE (NUM_STAGE),
                .AW        (din0_WIDTH),
                .BW        (din1_WIDTH),
                .OW        (dout_WIDTH),
                .SHIFT     (SHIFT),
                .ROUND     (ROUND),
                .SAT       (SAT)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .adv   (adv),
                .a     (din0[l*din0_WIDTH +: din0_WIDTH]),
                .b     (din1[l*din1_WIDTH +: din1_WIDTH]),
                .dout  (dout[l*dout_WIDTH +: dout_WIDTH]),
                .ovf   (ovf[l])
            );
        end
    endgenerate

endmodule

// File: tb/tb_myproject_mul_pipe_rs.sv
// Directed bench: default, truncating, wrapping and 4-lane/3-stage instances share one handshake.
module tb_myproject_mul_pipe_rs;

    logic clk = 1'b0;
    logic reset, ce, in_valid, out_ready, ovf_clr;
    logic [13:0] din0;
    logic [11:0] din1;
    logic [55:0] din0_l4;
    logic [47:0] din1_l4;

    logic        in_ready, out_valid;
    logic [15:0] dout, ovf_cnt;
    logic [0:0]  ovf;
    logic        in_ready_tr, out_valid_tr;
    logic [15:0] dout_tr, ovf_cnt_tr;
    logic [0:0]  ovf_tr;
    logic        in_ready_wr, out_valid_wr;
    logic [15:0] dout_wr, ovf_cnt_wr;
    logic [0:0]  ovf_wr;
    logic        in_ready_l4, out_valid_l4;
    logic [63:0] dout_l4;
    logic [15:0] ovf_cnt_l4;
    logic [3:0]  ovf_l4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    myproject_mul_pipe_rs #(.ID(1)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .ovf(ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr));

    myproject_mul_pipe_rs #(.ID(2), .ROUND(1'b0)) dut_tr (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_tr),
        .din0(din0), .din1(din1), .out_valid(out_valid_tr), .out_ready(out_ready),
        .dout(dout_tr), .ovf(ovf_tr), .ovf_cnt(ovf_cnt_tr), .ovf_clr(ovf_clr));

    myproject_mul_pipe_rs #(.ID(3), .SAT(1'b0)) dut_wr (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_wr),
        .din0(din0), .din1(din1), .out_valid(out_valid_wr), .out_ready(out_ready),
        .dout(dout_wr), .ovf(ovf_wr), .ovf_cnt(ovf_cnt_wr), .ovf_clr(ovf_clr));

    myproject_mul_pipe_rs #(.ID(4), .LANES(4), .NUM_STAGE(3), .SHIFT(0)) dut_l4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_l4),
        .din0(din0_l4), .din1(din1_l4), .out_valid(out_valid_l4), .out_ready(out_ready),
        .dout(dout_l4), .ovf(ovf_l4), .ovf_cnt(ovf_cnt_l4), .ovf_clr(ovf_clr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        din0 = '0; din1 = '0; din0_l4 = '0; din1_l4 = '0;
        reset = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (dout !== 16'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf got=%b/%0d exp=0/0", ovf, ovf_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_basic();
        din0 = 14'd100; din1 = 12'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
        checks++; if (dout !== 16'd78 || ovf !== 1'b0) begin errors++; $display("FAIL basic_dout got=%0d/%b exp=78/0", dout, ovf); end
        checks++; if (dout_tr !== 16'd78 || dout_wr !== 16'd78) begin errors++; $display("FAIL basic_variants got=%0d/%0d exp=78/78", dout_tr, dout_wr); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_round();
        din0 = -14'd3; din1 = 12'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (dout !== 16'd0) begin errors++; $display("FAIL round_half_up got=%h exp=0000", dout); end
        checks++; if (dout_tr !== 16'hFFFF) begin errors++; $display("FAIL round_trunc got=%h exp=ffff", dout_tr); end
        checks++; if (ovf !== 1'b0 || ovf_tr !== 1'b0) begin errors++; $display("FAIL round_ovf got=%b/%b exp=0/0", ovf, ovf_tr); end
        step();
    endtask

    task automatic test_sat();
        din0 = 14'd8191; din1 = 12'd2047; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (dout !== 16'h7FFF || ovf !== 1'b1) begin errors++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", dout, ovf); end
        checks++; if (dout_wr !== 16'hFFD8 || ovf_wr !== 1'b1) begin errors++; $display("FAIL wrap_pos got=%h/%b exp=ffd8/1", dout_wr, ovf_wr); end
        checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL cnt_before_xfer got=%0d exp=0", ovf_cnt); end
        step();
        checks++; if (ovf_cnt !== 16'd1 || ovf_cnt_wr !== 16'd1) begin errors++; $display("FAIL cnt_one got=%0d/%0d exp=1/1", ovf_cnt, ovf_cnt_wr); end
        din0 = 14'h2000; din1 = 12'd2047; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (dout !== 16'h8000 || ovf !== 1'b1) begin errors++; $display("FAIL sat_neg got=%h/%b exp=8000/1", dout, ovf); end
        checks++; if (dout_wr !== 16'd32 || ovf_wr !== 1'b1) begin errors++; $display("FAIL wrap_neg got=%h/%b exp=0020/1", dout_wr, ovf_wr); end
        step();
        checks++; if (ovf_cnt !== 16'd2) begin errors++; $display("FAIL cnt_two got=%0d exp=2", ovf_cnt); end
    endtask

    task automatic test_ce();
        din0 = 14'd100; din1 = 12'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        ce = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ce_in_ready got=%b exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || dout !== 16'd78) begin errors++; $display("FAIL ce_hold got=%b/%0d exp=1/78", out_valid, dout); end
        ce = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ce_resume got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int sent, rcv;
        bit prev_stall, acc, xf;
        logic [15:0] prev_dout;
        sent = 0; rcv = 0; prev_stall = 1'b0; prev_dout = '0;
        for (int c = 0; c < 40 && rcv < 10; c++) begin
            in_valid  = (sent < 10);
            din0      = 14'(256 * (sent + 1));
            din1      = 12'd1;
            out_ready = !(c >= 3 && c <= 6);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || dout !== prev_dout) begin errors++; $display("FAIL stall_hold c=%0d got=%b/%0d exp=1/%0d", c, out_valid, dout, prev_dout); end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, in_ready); end
            end
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                checks++;
                if (dout !== 16'(rcv + 1)) begin errors++; $display("FAIL stream_order got=%0d exp=%0d", dout, rcv + 1); end
                rcv++;
            end
            if (acc) sent++;
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcv != 10 || sent != 10) begin errors++; $display("FAIL stream_count got=%0d/%0d exp=10/10", sent, rcv); end
        step(); step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra got=%b exp=0", out_valid); end
        step(); step();
    endtask

    task automatic test_lanes();
        din0_l4 = {14'd0, 14'd127, -14'd2, 14'd1};
        din1_l4 = {12'd5, -12'd1, 12'd3, 12'd1};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid_l4 !== 1'b0) begin errors++; $display("FAIL l4_early got=%b exp=0", out_valid_l4); end
        step();
        checks++; if (out_valid_l4 !== 1'b1) begin errors++; $display("FAIL l4_latency got=%b exp=1", out_valid_l4); end
        checks++; if (dout_l4 !== {16'd0, 16'hFF81, 16'hFFFA, 16'd1}) begin errors++; $display("FAIL l4_dout got=%h exp=0000ff81fffa0001", dout_l4); end
        checks++; if (ovf_l4 !== 4'b0000) begin errors++; $display("FAIL l4_ovf got=%b exp=0000", ovf_l4); end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0;
        din0 = 14'd8191; din1 = 12'd2047; in_valid = 1'b1;
        step();
        din0 = 14'd100; din1 = 12'd200;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || ovf_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset got=%b/%0d exp=0/0", out_valid, ovf_cnt); end
        checks++; if (dout !== 16'd0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_dout got=%h/%b exp=0/0", dout, ovf); end
        step();
        reset = 1'b0; out_ready = 1'b1;
        din0 = 14'd100; din1 = 12'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                n++;
                checks++; if (dout !== 16'd78) begin errors++; $display("FAIL mid_after_dout got=%0d exp=78", dout); end
            end
            step();
        end
        checks++; if (n != 1) begin errors++; $display("FAIL mid_after_beats got=%0d exp=1", n); end
    endtask

    task automatic test_ovf_clr();
        out_ready = 1'b1;
        din0 = 14'd8191; din1 = 12'd2047; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre got=%0d exp=1", ovf_cnt); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL clr_priority got=%0d exp=0", ovf_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_sat();
        test_ce();
        test_back_to_back();
        test_lanes();
        test_reset_mid();
        test_ovf_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
